// File: rtl/rotation_sequencer.sv
// Homing and shortest-path move controller for the 32-position red-mark ring.
// Tracks the mark position and cross-checks both sensors after every settled step.
module rotation_sequencer #(
  parameter int WIDTH      = 32,
  parameter int SENSA_POS  = 23,
  parameter int SENSB_POS  = 7,
  parameter int STEP_GAP   = 4,
  parameter int HOME_LIMIT = 64,
  localparam int PW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_home,
  input  logic [PW-1:0] cmd_target,
  output logic          left,
  output logic          right,
  input  logic          sensorA,
  input  logic          sensorB,
  output logic [PW-1:0] pos,
  output logic          pos_valid,
  output logic          busy,
  output logic          done,
  output logic          done_ok,
  output logic          err
);
  localparam int WW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;
  localparam int HW = $clog2(HOME_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, HOME_STEP, HOME_WAIT, MOVE_STEP, MOVE_WAIT, FAULT} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wcnt;
  logic [HW-1:0] hcnt;
  logic [PW-1:0] rem;
  logic          dir_left;
  logic          done_nxt, ok_nxt;
  logic          accept, wait_end, sens_ok;
  logic [PW-1:0] diff;

  assign accept   = cmd_valid && cmd_ready;
  assign diff     = cmd_target - pos;
  assign wait_end = (wcnt == WW'(STEP_GAP - 1));
  assign sens_ok  = (sensorA == (pos == PW'(SENSA_POS))) && (sensorB == (pos == PW'(SENSB_POS)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    ok_nxt    = 1'b0;
    case (state)
      IDLE, FAULT: if (accept) begin
        if (cmd_home)          state_nxt = HOME_STEP;
        else if (!pos_valid)   done_nxt  = 1'b1;
        else if (diff == '0) begin done_nxt = 1'b1; ok_nxt = 1'b1; end
        else                   state_nxt = MOVE_STEP;
      end
      HOME_STEP: state_nxt = HOME_WAIT;
      HOME_WAIT: if (wait_end) begin
        if (sensorB) begin state_nxt = IDLE; done_nxt = 1'b1; ok_nxt = 1'b1; end
        else if (hcnt == HW'(HOME_LIMIT)) begin state_nxt = FAULT; done_nxt = 1'b1; end
        else state_nxt = HOME_STEP;
      end
      MOVE_STEP: state_nxt = MOVE_WAIT;
      MOVE_WAIT: if (wait_end) begin
        if (!sens_ok)        begin state_nxt = FAULT; done_nxt = 1'b1; end
        else if (rem == '0)  begin state_nxt = IDLE; done_nxt = 1'b1; ok_nxt = 1'b1; end
        else state_nxt = MOVE_STEP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE || state == FAULT) && !rst;
    busy      = (state == HOME_STEP) || (state == HOME_WAIT) ||
                (state == MOVE_STEP) || (state == MOVE_WAIT);
    left      = (state == HOME_STEP) || (state == MOVE_STEP && dir_left);
    right     = (state == MOVE_STEP) && !dir_left;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= '0; pos_valid <= 1'b0; err <= 1'b0; done <= 1'b0; done_ok <= 1'b0;
      wcnt <= '0; hcnt <= '0; rem <= '0; dir_left <= 1'b0;
    end else begin
      done    <= done_nxt;
      done_ok <= ok_nxt;
      case (state)
        IDLE, FAULT: if (accept) begin
          if (cmd_home) begin
            hcnt      <= '0;
            pos_valid <= 1'b0;   // the ring is about to move under an unknown origin
          end else if (pos_valid) begin
            // ties at half a turn go left; WIDTH-d is just -d in PW bits
            dir_left <= (diff <= PW'(WIDTH / 2));
            rem      <= (diff <= PW'(WIDTH / 2)) ? diff : PW'(0) - diff;
          end
        end
        HOME_STEP: begin hcnt <= hcnt + HW'(1); wcnt <= '0; end
        MOVE_STEP: begin
          pos  <= dir_left ? pos + PW'(1) : pos - PW'(1);
          rem  <= rem - PW'(1);
          wcnt <= '0;
        end
        HOME_WAIT: begin
          wcnt <= wcnt + WW'(1);
          if (wait_end && sensorB) begin
            pos <= PW'(SENSB_POS); pos_valid <= 1'b1; err <= 1'b0;
          end else if (wait_end && hcnt == HW'(HOME_LIMIT)) begin
            err <= 1'b1; pos_valid <= 1'b0;
          end
        end
        MOVE_WAIT: begin
          wcnt <= wcnt + WW'(1);
          if (wait_end && !sens_ok) begin err <= 1'b1; pos_valid <= 1'b0; end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rotation_sequencer.sv
// Bench for rotation_sequencer: a 32-position ring model drives the sensors and
// expected pulse counts/latencies come from shortest-path arithmetic on the ring.
module tb_rotation_sequencer;
  logic       clk = 0, rst = 1;
  logic       cmd_valid = 0, cmd_ready, cmd_home = 0;
  logic [4:0] cmd_target = 0;
  logic       left, right, sensorA, sensorB, pos_valid, busy, done, done_ok, err;
  logic [4:0] pos;

  int  ring_p = 0;     // physical mark position
  int  lcount = 0, rcount = 0;
  bit  forceA = 0;
  int  n_chk = 0, n_fail = 0;

  rotation_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_home(cmd_home), .cmd_target(cmd_target), .left(left), .right(right),
    .sensorA(sensorA), .sensorB(sensorB), .pos(pos), .pos_valid(pos_valid),
    .busy(busy), .done(done), .done_ok(done_ok), .err(err)
  );

  always #5 clk = ~clk;

  assign sensorA = (ring_p == 23) || forceA;
  assign sensorB = (ring_p == 7);

  always @(posedge clk) begin
    if (left && right) begin
      n_chk++; n_fail++;
      $display("FAIL both_pulses: left=%0b right=%0b required not both 1", left, right);
    end
    if (left)  begin ring_p <= (ring_p + 1) % 32;  lcount <= lcount + 1; end
    if (right) begin ring_p <= (ring_p + 31) % 32; rcount <= rcount + 1; end
  end

  // Issues one command; lat = cycles from acceptance to done (-1 on timeout).
  task automatic do_cmd(input bit home, input int tgt, output int lat, output bit ok,
                        output int lp, output int rp);
    int l0, r0, w;
    @(negedge clk);
    cmd_valid = 1; cmd_home = home; cmd_target = 5'(tgt);
    w = 0;
    while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
    l0 = lcount; r0 = rcount;
    @(posedge clk); #1 cmd_valid = 0;
    lat = -1; ok = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (done) begin lat = n; ok = done_ok; break; end
    end
    lp = lcount - l0; rp = rcount - r0;
  endtask

  function automatic int home_steps(input int p);
    return ((7 - p - 1 + 64) % 32) + 1;
  endfunction

  task automatic test_reset();
    rst = 1; ring_p = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (cmd_ready !== 0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", cmd_ready); end
    rst = 0;
    @(negedge clk);
    n_chk++;
    if ({left, right, pos_valid, busy, done, done_ok, err} !== 7'b0 || pos !== 0 || cmd_ready !== 1) begin
      n_fail++;
      $display("FAIL reset_vals: l%0b r%0b pv%0b b%0b d%0b ok%0b e%0b pos%0d rdy%0b want zeros, rdy=1",
               left, right, pos_valid, busy, done, done_ok, err, pos, cmd_ready);
    end
  endtask

  task automatic test_home();
    int lat, lp, rp, es; bit ok;
    es = home_steps(ring_p);
    do_cmd(1, 0, lat, ok, lp, rp);
    n_chk++; if (lat !== 1 + es * 5) begin n_fail++; $display("FAIL home_latency: got %0d want %0d", lat, 1 + es * 5); end
    n_chk++; if (lp !== es || rp !== 0) begin n_fail++; $display("FAIL home_pulses: got L%0d R%0d want L%0d R0", lp, rp, es); end
    n_chk++;
    if (ok !== 1 || pos !== 7 || pos_valid !== 1 || err !== 0) begin
      n_fail++; $display("FAIL home_result: ok%0b pos%0d pv%0b err%0b want 1,7,1,0", ok, pos, pos_valid, err);
    end
  endtask

  // Shortest-path move, checked against the ring model.
  task automatic move_check(input string name, input int tgt);
    int lat, lp, rp, d, el, er; bit ok;
    d  = (tgt - ring_p + 32) % 32;
    el = (d <= 16) ? d : 0;
    er = (d > 16) ? 32 - d : 0;
    do_cmd(0, tgt, lat, ok, lp, rp);
    n_chk++;
    if (lat !== 1 + (el + er) * 5 || ok !== 1) begin
      n_fail++; $display("FAIL %s_done: lat %0d ok %0b want lat %0d ok 1", name, lat, ok, 1 + (el + er) * 5);
    end
    n_chk++;
    if (lp !== el || rp !== er) begin
      n_fail++; $display("FAIL %s_pulses: got L%0d R%0d want L%0d R%0d", name, lp, rp, el, er);
    end
    n_chk++;
    if (pos !== 5'(tgt) || ring_p !== tgt || pos_valid !== 1) begin
      n_fail++; $display("FAIL %s_pos: pos %0d ring %0d pv %0b want %0d", name, pos, ring_p, pos_valid, tgt);
    end
  endtask

  task automatic test_tie();
    move_check("tie", 23);
    n_chk++; if (sensorA !== 1) begin n_fail++; $display("FAIL tie_sensorA: got %0b want 1", sensorA); end
  endtask

  task automatic test_wrap();
    move_check("wrap_left", 3);
    move_check("right", 20);
  endtask

  task automatic test_unhomed();
    int lat, lp, rp; bit ok;
    rst = 1; @(negedge clk); rst = 0;
    do_cmd(0, 5, lat, ok, lp, rp);
    n_chk++;
    if (lat !== 1 || ok !== 0 || lp !== 0 || rp !== 0 || pos_valid !== 0) begin
      n_fail++; $display("FAIL unhomed_move: lat%0d ok%0b L%0d R%0d pv%0b want 1,0,0,0,0", lat, ok, lp, rp, pos_valid);
    end
  endtask

  task automatic test_sensor_fault();
    int lat, lp, rp; bit ok;
    test_home();
    move_check("pre_fault", 3);
    forceA = 1;
    do_cmd(0, 10, lat, ok, lp, rp);
    n_chk++;
    if (lat !== 6 || ok !== 0 || err !== 1 || pos_valid !== 0 || busy !== 0) begin
      n_fail++; $display("FAIL fault_detect: lat%0d ok%0b err%0b pv%0b busy%0b want 6,0,1,0,0", lat, ok, err, pos_valid, busy);
    end
    do_cmd(0, 12, lat, ok, lp, rp);
    n_chk++;
    if (lat !== 1 || ok !== 0 || lp !== 0 || rp !== 0 || err !== 1) begin
      n_fail++; $display("FAIL fault_reject: lat%0d ok%0b L%0d R%0d err%0b want 1,0,0,0,1", lat, ok, lp, rp, err);
    end
    forceA = 0;
    test_home();
  endtask

  task automatic test_random_moves();
    for (int i = 0; i < 10; i++) move_check("rand", int'($urandom_range(0, 31)));
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    saw_done = 0;
    move_check("to_7", 7);
    @(negedge clk);
    cmd_valid = 1; cmd_home = 0; cmd_target = 5'd17;
    @(posedge clk); #1 cmd_valid = 0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    n_chk++; if (left !== 1 || busy !== 1) begin n_fail++; $display("FAIL mid_step4: left%0b busy%0b want 1,1", left, busy); end
    saw_done = saw_done | done;
    rst = 1;
    @(negedge clk);
    saw_done = saw_done | done;
    n_chk++;
    if ({left, right, pos_valid, busy, done, done_ok, err} !== 7'b0 || pos !== 0) begin
      n_fail++; $display("FAIL mid_reset_vals: l%0b r%0b pv%0b b%0b d%0b pos%0d want zeros",
                         left, right, pos_valid, busy, done, pos);
    end
    rst = 0;
    repeat (60) begin @(negedge clk); saw_done = saw_done | done; end
    n_chk++; if (saw_done !== 0 || busy !== 0) begin n_fail++; $display("FAIL mid_no_done: done seen %0b busy %0b want 0,0", saw_done, busy); end
  endtask

  initial begin
    test_reset();
    test_home();
    test_tie();
    test_wrap();
    test_unhomed();
    test_sensor_fault();
    test_random_moves();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
